// File: rtl/tt_ran_ctrl.sv
// tt_ran_ctrl: ring-oscillator TRNG controller.
// Warms up the inverter ring, collects four raw-bit samples into a key and
// hands it to a ready/valid consumer. A repetition-count health test trips
// into a sticky failure state when the entropy source looks stuck.
module tt_ran_ctrl #(
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       rawbit_i,
    input  logic       key_ready_i,
    output logic       ring_en_o,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    output logic       busy_o,
    output logic       fail_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        COLLECT = 3'd2,
        PRESENT = 3'd3,
        FAIL    = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cyc_cnt_q;
    logic [3:0] div_q;
    logic [1:0] bit_cnt_q;
    logic [3:0] rep_cnt_q;
    logic [3:0] rep_next;
    logic [3:0] key_q;
    logic       fail_q;
    logic       ring_en_q;
    logic       warm_done;
    logic       div_last;
    logic       sample_tick;
    logic       rep_hit;
    logic       key_done;

    assign warm_done   = (cyc_cnt_q == 8'(WARMUP_CYCLES - 1));
    assign div_last    = (div_q == 4'(SAMPLE_DIV - 1));
    assign sample_tick = (state_q == COLLECT) && start_i && div_last;
    assign rep_hit     = (rep_next == 4'(REP_LIMIT));
    assign key_done    = (bit_cnt_q == 2'd3);

    // Repetition count the current raw bit would produce; key_q[0] is the previous sample.
    always_comb begin
        rep_next = 4'd1;
        if ((rep_cnt_q != 4'd0) && (rawbit_i == key_q[0])) begin
            rep_next = (rep_cnt_q == 4'(REP_LIMIT)) ? rep_cnt_q : rep_cnt_q + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; aborts win over sampling, health failure wins over key completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = WARMUP;
            end
            WARMUP: begin
                if (!start_i)       state_d = IDLE;
                else if (warm_done) state_d = COLLECT;
            end
            COLLECT: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else if (sample_tick) begin
                    if (rep_hit)       state_d = FAIL;
                    else if (key_done) state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (key_ready_i) state_d = start_i ? COLLECT : IDLE;
            end
            FAIL: begin
                if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, key shift register and sticky fail flag; the divider keeps running while a key is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= 8'd0;
            div_q     <= 4'd0;
            bit_cnt_q <= 2'd0;
            rep_cnt_q <= 4'd0;
            key_q     <= 4'd0;
            fail_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cyc_cnt_q <= 8'd0;
                    div_q     <= 4'd0;
                    bit_cnt_q <= 2'd0;
                    rep_cnt_q <= 4'd0;
                    if (start_i) fail_q <= 1'b0;
                end
                WARMUP: begin
                    div_q     <= 4'd0;
                    cyc_cnt_q <= start_i ? cyc_cnt_q + 8'd1 : 8'd0;
                end
                COLLECT: begin
                    if (!start_i) begin
                        bit_cnt_q <= 2'd0;
                        div_q     <= 4'd0;
                    end else begin
                        div_q <= div_last ? 4'd0 : div_q + 4'd1;
                        if (div_last) begin
                            key_q     <= {key_q[2:0], rawbit_i};
                            bit_cnt_q <= bit_cnt_q + 2'd1;
                            rep_cnt_q <= rep_next;
                            if (rep_hit) fail_q <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    div_q <= div_last ? 4'd0 : div_q + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Ring enable is registered from the next state so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_en_q <= 1'b0;
        end else begin
            ring_en_q <= (state_d == WARMUP) || (state_d == COLLECT) || (state_d == PRESENT);
        end
    end

    // Output decode.
    always_comb begin
        busy_o      = (state_q == WARMUP) || (state_q == COLLECT) || (state_q == PRESENT);
        key_valid_o = (state_q == PRESENT);
    end

    assign ring_en_o = ring_en_q;
    assign key_o     = key_q;
    assign fail_o    = fail_q;

endmodule

// File: tb/tb_tt_ran_ctrl.sv
// tb_tt_ran_ctrl: directed scenario tasks plus a randomized run checked
// against a behavioural model of the TRNG controller.
module tb_tt_ran_ctrl;

    localparam int W = 64;
    localparam int D = 4;
    localparam int R = 8;

    localparam int M_IDLE    = 0;
    localparam int M_WARM    = 1;
    localparam int M_COLLECT = 2;
    localparam int M_PRESENT = 3;
    localparam int M_FAIL    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic       rawbit_i;
    logic       key_ready_i;
    logic       ring_en_o;
    logic [3:0] key_o;
    logic       key_valid_o;
    logic       busy_o;
    logic       fail_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_n       = 0;

    int         m_mode;
    int         m_warm_left;
    int         m_ticks;
    int         m_nbits;
    int         m_run;
    logic       m_last;
    logic [3:0] m_key;
    logic       m_fail;

    tt_ran_ctrl #(
        .WARMUP_CYCLES(W),
        .SAMPLE_DIV(D),
        .REP_LIMIT(R)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .rawbit_i(rawbit_i),
        .ring_en_o(ring_en_o),
        .key_o(key_o),
        .key_valid_o(key_valid_o),
        .key_ready_i(key_ready_i),
        .busy_o(busy_o),
        .fail_o(fail_o)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_mode      = M_IDLE;
        m_warm_left = 0;
        m_ticks     = 0;
        m_nbits     = 0;
        m_run       = 0;
        m_last      = 1'b0;
        m_key       = 4'h0;
        m_fail      = 1'b0;
    endtask

    // Behavioural model: one call per rising edge using the inputs seen at that edge.
    task automatic model_step();
        bit sample;
        case (m_mode)
            M_IDLE: begin
                if (start_i) begin
                    m_mode      = M_WARM;
                    m_warm_left = W;
                    m_fail      = 1'b0;
                    m_run       = 0;
                    m_nbits     = 0;
                end
            end
            M_WARM: begin
                if (!start_i) begin
                    m_mode = M_IDLE;
                end else begin
                    m_warm_left--;
                    if (m_warm_left == 0) begin
                        m_mode  = M_COLLECT;
                        m_ticks = 0;
                    end
                end
            end
            M_COLLECT: begin
                if (!start_i) begin
                    m_mode  = M_IDLE;
                    m_nbits = 0;
                end else begin
                    sample = ((m_ticks % D) == D - 1);
                    m_ticks++;
                    if (sample) begin
                        if (m_run > 0 && rawbit_i == m_last) m_run = (m_run + 1 > R) ? R : m_run + 1;
                        else m_run = 1;
                        m_last = rawbit_i;
                        m_key  = {m_key[2:0], rawbit_i};
                        m_nbits++;
                        if (m_run >= R) begin
                            m_mode = M_FAIL;
                            m_fail = 1'b1;
                        end else if (m_nbits == 4) begin
                            m_nbits = 0;
                            m_mode  = M_PRESENT;
                        end
                    end
                end
            end
            M_PRESENT: begin
                m_ticks++;
                if (key_ready_i) m_mode = start_i ? M_COLLECT : M_IDLE;
            end
            default: begin
                if (!start_i) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        edge_n++;
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        start_i     = 1'b0;
        rawbit_i    = 1'b0;
        key_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = -1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start_i     = 1'b0;
        rawbit_i    = 1'b0;
        key_ready_i = 1'b0;
        model_reset();
        #2;
        tests_run++;
        if ({ring_en_o, key_o, key_valid_o, busy_o, fail_o} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b required 00000000",
                     {ring_en_o, key_o, key_valid_o, busy_o, fail_o});
        end
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = -1;
        tick();
        tests_run++;
        if ({ring_en_o, busy_o, key_valid_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got %b required 000", {ring_en_o, busy_o, key_valid_o});
        end
    endtask

    task automatic test_single_key();
        logic [3:0] pat = 4'b1011;
        logic [3:0] got_key = 4'h0;
        int         first_valid = -1;
        logic       valid81 = 1'b1;
        bit         ring_drop = 0;
        do_reset();
        start_i     = 1'b1;
        key_ready_i = 1'b1;
        tick();
        tests_run++;
        if ({ring_en_o, busy_o} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL warmup_entry: ring_en/busy got %b required 11", {ring_en_o, busy_o});
        end
        for (int e = 1; e <= 100; e++) begin
            if (e > 64 && e <= 80) rawbit_i = pat[3 - ((e - 65) / 4)];
            else rawbit_i = 1'($urandom_range(0, 1));
            tick();
            if (key_valid_o && first_valid < 0) begin
                first_valid = edge_n;
                got_key     = key_o;
            end
            if (edge_n <= 81 && !ring_en_o) ring_drop = 1;
            if (edge_n == 81) valid81 = key_valid_o;
        end
        tests_run++;
        if (first_valid != 80) begin
            tests_failed++;
            $display("[TB] FAIL first_key_latency: got edge %0d required 80", first_valid);
        end
        tests_run++;
        if (got_key !== 4'hB) begin
            tests_failed++;
            $display("[TB] FAIL first_key_value: got %h required b", got_key);
        end
        tests_run++;
        if (valid81 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL valid_one_cycle: key_valid after edge 81 got %b required 0", valid81);
        end
        tests_run++;
        if (ring_drop) begin
            tests_failed++;
            $display("[TB] FAIL ring_en_steady: ring_en dropped got 1 required 0 drops");
        end
    endtask

    task automatic test_continuous();
        int         last_pulse = -1;
        int         npulse = 0;
        bit         ring_drop = 0;
        bit         fail_seen = 0;
        bit         key_bad = 0;
        do_reset();
        start_i     = 1'b1;
        key_ready_i = 1'b1;
        tick();
        for (int e = 1; e <= 200; e++) begin
            rawbit_i = 1'((e / 4) & 1);
            tick();
            if (!ring_en_o) ring_drop = 1;
            if (fail_o) fail_seen = 1;
            if (key_valid_o) begin
                if (key_o !== 4'hA) key_bad = 1;
                if (last_pulse < 0) begin
                    tests_run++;
                    if (edge_n != 80) begin
                        tests_failed++;
                        $display("[TB] FAIL cont_first_pulse: got edge %0d required 80", edge_n);
                    end
                end else begin
                    tests_run++;
                    if (edge_n - last_pulse != 16) begin
                        tests_failed++;
                        $display("[TB] FAIL cont_pulse_gap: got %0d required 16", edge_n - last_pulse);
                    end
                end
                last_pulse = edge_n;
                npulse++;
            end
        end
        tests_run++;
        if (npulse != 8) begin
            tests_failed++;
            $display("[TB] FAIL cont_pulse_count: got %0d required 8", npulse);
        end
        tests_run++;
        if (ring_drop || fail_seen || key_bad) begin
            tests_failed++;
            $display("[TB] FAIL cont_steady: ring_drop/fail/key_bad got %b%b%b required 000",
                     ring_drop, fail_seen, key_bad);
        end
    endtask

    task automatic test_health();
        int fail_edge = -1;
        int nvalid = 0;
        do_reset();
        start_i     = 1'b1;
        key_ready_i = 1'b1;
        rawbit_i    = 1'b0;
        tick();
        for (int e = 1; e <= 120; e++) begin
            tick();
            if (fail_o && fail_edge < 0) fail_edge = edge_n;
            if (key_valid_o) nvalid++;
        end
        tests_run++;
        if (fail_edge != 96) begin
            tests_failed++;
            $display("[TB] FAIL health_fail_edge: got %0d required 96", fail_edge);
        end
        tests_run++;
        if (nvalid != 1) begin
            tests_failed++;
            $display("[TB] FAIL health_valid_count: got %0d required 1", nvalid);
        end
        tests_run++;
        if ({ring_en_o, busy_o, key_valid_o, fail_o} !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL health_fail_state: ring/busy/valid/fail got %b required 0001",
                     {ring_en_o, busy_o, key_valid_o, fail_o});
        end
        start_i = 1'b0;
        tick();
        tests_run++;
        if ({ring_en_o, busy_o, fail_o} !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL health_idle_sticky: ring/busy/fail got %b required 001",
                     {ring_en_o, busy_o, fail_o});
        end
        start_i = 1'b1;
        tick();
        tests_run++;
        if ({ring_en_o, busy_o, fail_o} !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL health_restart_clear: ring/busy/fail got %b required 110",
                     {ring_en_o, busy_o, fail_o});
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_key = 4'h0;
        int         unstable = 0;
        do_reset();
        start_i     = 1'b1;
        key_ready_i = 1'b0;
        tick();
        for (int e = 1; e <= 80; e++) begin
            rawbit_i = 1'($urandom_range(0, 1));
            if (e >= 68 && (e % 4) == 0) exp_key = {exp_key[2:0], rawbit_i};
            tick();
        end
        tests_run++;
        if ({key_valid_o, key_o} !== {1'b1, exp_key}) begin
            tests_failed++;
            $display("[TB] FAIL bp_key_present: valid,key got %b_%h required 1_%h", key_valid_o, key_o, exp_key);
        end
        for (int k = 1; k <= 20; k++) begin
            rawbit_i = ~rawbit_i;
            if (k == 10) start_i = 1'b0;
            tick();
            if (!key_valid_o || key_o !== exp_key) unstable++;
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold_stable: unstable cycles got %0d required 0", unstable);
        end
        key_ready_i = 1'b1;
        tick();
        tests_run++;
        if ({key_valid_o, busy_o, ring_en_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept_idle: valid/busy/ring got %b required 000",
                     {key_valid_o, busy_o, ring_en_o});
        end
    endtask

    task automatic test_abort();
        bit   valid_seen = 0;
        logic bit68 = 1'b0;
        int   first_valid = -1;
        do_reset();
        start_i     = 1'b1;
        key_ready_i = 1'b1;
        tick();
        for (int e = 1; e <= 69; e++) begin
            rawbit_i = 1'($urandom_range(0, 1));
            if (e == 68) bit68 = rawbit_i;
            tick();
            if (key_valid_o) valid_seen = 1;
        end
        start_i = 1'b0;
        tick();
        tests_run++;
        if ({ring_en_o, busy_o, key_valid_o, valid_seen} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle: ring/busy/valid/seen got %b required 0000",
                     {ring_en_o, busy_o, key_valid_o, valid_seen});
        end
        tests_run++;
        if (key_o !== {3'b000, bit68}) begin
            tests_failed++;
            $display("[TB] FAIL abort_key_hold: got %h required %h", key_o, {3'b000, bit68});
        end
        start_i = 1'b1;
        edge_n  = -1;
        tick();
        for (int e = 1; e <= 100; e++) begin
            rawbit_i = 1'($urandom_range(0, 1));
            tick();
            if (key_valid_o && first_valid < 0) first_valid = edge_n;
        end
        tests_run++;
        if (first_valid != 80) begin
            tests_failed++;
            $display("[TB] FAIL abort_restart_latency: got edge %0d required 80", first_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_i     = 1'b1;
        key_ready_i = 1'b0;
        tick();
        for (int e = 1; e <= 80; e++) begin
            rawbit_i = 1'($urandom_range(0, 1));
            tick();
        end
        tests_run++;
        if (key_valid_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL areset_precond: key_valid got %b required 1", key_valid_o);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if ({ring_en_o, key_o, key_valid_o, busy_o, fail_o} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL areset_immediate: got %b required 00000000",
                     {ring_en_o, key_o, key_valid_o, busy_o, fail_o});
        end
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({ring_en_o, busy_o, key_valid_o} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL areset_idle: ring/busy/valid got %b required 000",
                     {ring_en_o, busy_o, key_valid_o});
        end
    endtask

    task automatic test_random();
        bit   stuck = 0;
        logic stuck_val = 1'b0;
        int   nprint = 0;
        logic exp_act;
        do_reset();
        start_i = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ((c % 250) == 0) begin
                stuck     = ($urandom_range(0, 2) == 0);
                stuck_val = 1'($urandom_range(0, 1));
            end
            rawbit_i    = stuck ? stuck_val : 1'($urandom_range(0, 1));
            key_ready_i = ($urandom_range(0, 3) != 0);
            if (start_i) begin
                if ($urandom_range(0, 299) == 0) start_i = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) start_i = 1'b1;
            end
            tick();
            exp_act = (m_mode == M_WARM) || (m_mode == M_COLLECT) || (m_mode == M_PRESENT);
            tests_run++;
            if ({ring_en_o, busy_o, key_valid_o, fail_o, key_o} !==
                {exp_act, exp_act, (m_mode == M_PRESENT), m_fail, m_key}) begin
                tests_failed++;
                if (nprint < 10) begin
                    nprint++;
                    $display("[TB] FAIL random_model cycle %0d: ring/busy/valid/fail/key got %b%b%b%b_%h required %b%b%b%b_%h",
                             c, ring_en_o, busy_o, key_valid_o, fail_o, key_o,
                             exp_act, exp_act, (m_mode == M_PRESENT), m_fail, m_key);
                end
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_single_key();
        test_continuous();
        test_health();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
